// File: rtl/mem_pkg.sv
// Purpose: shared types and lane helpers for the SRAM load/store initiator.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
// Contents: size_e, state_e, lane_extract, lane_merge, align_lo, is_misaligned.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_MRG  = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // Pull a byte/half out of a little-endian word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  addr_lo,
                                               input size_e       size,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overwrite one byte/half lane of a word with right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  addr_lo,
                                             input size_e       size);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B: begin
        case (addr_lo)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (addr_lo[1]) r[31:16] = wdata[15:0];
        else            r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Force the low address bits to the natural alignment of the access.
  function automatic logic [1:0] align_lo(input logic [1:0] addr_lo, input size_e size);
    case (size)
      SZ_B:    return addr_lo;
      SZ_H:    return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input size_e size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Purpose: combinational lane extract (loads) and lane merge (sub-word stores).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: word (SRAM read data), wdata, addr_lo, size, is_unsigned -> ext, merged.
module mem_lane
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  assign ext    = lane_extract(word, addr_lo, size, is_unsigned);
  assign merged = lane_merge(word, wdata, addr_lo, size);

endmodule

// File: rtl/mem_req_ctrl.sv
// Purpose: byte/half/word load-store initiator for one SRAM port; sub-word stores via read-modify-write.
// Latency: load and sub-word store respond in T+2, word store (and rejected access) in T+1.
// Backpressure: one request in flight; req_ready low until the response is taken, rsp_ready low holds RSP.
// Ports: req_* (valid/ready request), rsp_* (valid/ready response), mem_* (SRAM port, 1-cycle read).
// Build option: define MISALIGN_CHK_EN to reject misaligned / reserved-size accesses with rsp_err.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW+1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [1:0]    lo;
    size_e         size;
    logic          uns;
    logic [31:0]   wdata;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic        accept;
  size_e       in_size;
  logic [1:0]  in_lo;
  logic        in_bad;
  logic [31:0] lane_ext;
  logic [31:0] lane_merged;

  // Gating with rst_n keeps the SRAM port and handshake quiet while reset is held.
  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_rdata = rdata_q;

  always_comb begin
    in_size = size_e'(req_size);
`ifdef MISALIGN_CHK_EN
    in_lo   = req_addr[1:0];
    in_bad  = is_misaligned(req_addr[1:0], in_size);
`else
    if (in_size == SZ_RSV) in_size = SZ_W;
    in_lo   = align_lo(req_addr[1:0], in_size);
    in_bad  = 1'b0;
`endif
  end

  mem_lane u_lane (
    .word        (mem_dout),
    .wdata       (req_q.wdata),
    .addr_lo     (req_q.lo),
    .size        (req_q.size),
    .is_unsigned (req_q.uns),
    .ext         (lane_ext),
    .merged      (lane_merged)
  );

  always_comb begin
    state_d  = state_q;
    mem_en   = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = req_q.waddr;
    mem_din  = lane_merged;
    case (state_q)
      ST_IDLE: begin
        // Accept cycle drives the port straight from the request inputs.
        mem_addr = req_addr[AW+1:2];
        mem_din  = req_wdata;
        if (accept) begin
          if (in_bad) begin
            state_d = ST_RSP;
          end else if (!req_we) begin
            mem_en  = 1'b1;
            state_d = ST_RD;
          end else if (in_size == SZ_W) begin
            mem_en  = 1'b1;
            mem_wen = 1'b1;
            state_d = ST_RSP;
          end else begin
            mem_en  = 1'b1;
            state_d = ST_MRG;
          end
        end
      end
      ST_RD: begin
        state_d = ST_RSP;
      end
      ST_MRG: begin
        // mem_dout holds the word read in the accept cycle; write it back merged.
        mem_en  = 1'b1;
        mem_wen = 1'b1;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.waddr <= req_addr[AW+1:2];
        req_q.lo    <= in_lo;
        req_q.size  <= in_size;
        req_q.uns   <= req_unsigned;
        req_q.wdata <= req_wdata;
        // Stores and rejected accesses return zero; loads overwrite this in RD.
        rdata_q     <= '0;
      end
      if (state_q == ST_RD) rdata_q <= lane_ext;
    end
  end

`ifdef MISALIGN_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= in_bad;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_req_ctrl #(.AW(AW), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // SRAM model: registered read, write on the edge, no byte enables.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) sram[mem_addr] <= mem_din;
      else         mem_dout <= sram[mem_addr];
    end
  end

  int en_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (mem_en === 1'b1) en_cnt++;
    if (mem_en === 1'b1 && mem_wen === 1'b1) wr_cnt++;
  end

  // Called aligned to posedge+1; returns aligned to posedge+1.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    exp_t e;
    logic is_w;
    int exp_en, exp_wr, en0, wr0, cyc;
    logic [31:0] held;
    is_w    = (size == 2'd2) || (size == 2'd3);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = (exp_err || (we && is_w)) ? 1 : 2;
    exp_en  = exp_err ? 0 : ((we && !is_w) ? 2 : 1);
    exp_wr  = (!exp_err && we) ? 1 : 0;
    sb.push_back(e);
    en0 = en_cnt;
    wr0 = wr_cnt;
    rsp_ready    = (hold == 0);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_T got %b want 1", name, req_ready);
    end
    checks++;
    if (mem_en !== (exp_en != 0) || mem_wen !== (exp_wr == 1 && e.lat == 1)) begin
      errors++; $display("FAIL %s port_T got en=%b wen=%b want en=%b wen=%b", name,
                         mem_en, mem_wen, (exp_en != 0), (exp_wr == 1 && e.lat == 1));
    end
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = 12'($urandom);
    req_wdata    = $urandom;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid === 1'b1 || cyc >= 10) break;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL %s rsp_timeout got rsp_valid=%b want 1 within 10 cycles", name, rsp_valid);
      void'(sb.pop_front());
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      return;
    end
    e = sb.pop_front();
    if (cyc != e.lat) begin
      errors++; $display("FAIL %s latency got T+%0d want T+%0d", name, cyc, e.lat);
    end
    checks++;
    if (rsp_rdata !== e.rdata) begin
      errors++; $display("FAIL %s rdata got %08h want %08h", name, rsp_rdata, e.rdata);
    end
    checks++;
    if (rsp_err !== e.err) begin
      errors++; $display("FAIL %s err got %b want %b", name, rsp_err, e.err);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL %s req_ready_rsp got %b want 0", name, req_ready);
    end
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== held || mem_en !== 1'b0) begin
        errors++; $display("FAIL %s hold%0d got v=%b rdy=%b d=%08h en=%b want v=1 rdy=0 d=%08h en=0",
                           name, i, rsp_valid, req_ready, rsp_rdata, mem_en, held);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_hs got v=%b rdy=%b want v=0 rdy=1", name, rsp_valid, req_ready);
    end
    checks++;
    if (en_cnt - en0 != exp_en || wr_cnt - wr0 != exp_wr) begin
      errors++; $display("FAIL %s sram_access got en=%0d wr=%0d want en=%0d wr=%0d", name,
                         en_cnt - en0, wr_cnt - wr0, exp_en, exp_wr);
    end
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] want);
    checks++;
    if (sram[idx] !== want) begin
      errors++; $display("FAIL %s sram[%0d] got %08h want %08h", name, idx, sram[idx], want);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    #12;
    checks++;
    if (req_ready !== 1'b0 || mem_en !== 1'b0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL reset_port got rdy=%b en=%b wen=%b want 0 0 0", req_ready, mem_en, mem_wen);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got v=%b d=%08h e=%b want 0 00000000 0", rsp_valid, rsp_rdata, rsp_err);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    do_req("st_w_preload", 1, 2'd2, 0, 12'h010, 32'h8899AABB, 32'h0, 0, 0);
    check_word("preload", 4, 32'h8899AABB);
    do_req("ld_b_s_12",  0, 2'd0, 0, 12'h012, 32'h0, 32'hFFFFFF99, 0, 0);
    do_req("ld_b_u_12",  0, 2'd0, 1, 12'h012, 32'h0, 32'h00000099, 0, 0);
    do_req("ld_b_s_13",  0, 2'd0, 0, 12'h013, 32'h0, 32'hFFFFFF88, 0, 0);
    do_req("ld_b_s_11",  0, 2'd0, 0, 12'h011, 32'h0, 32'hFFFFFFAA, 0, 0);
    do_req("ld_h_s_10",  0, 2'd1, 0, 12'h010, 32'h0, 32'hFFFFAABB, 0, 0);
    do_req("ld_h_u_12",  0, 2'd1, 1, 12'h012, 32'h0, 32'h00008899, 0, 0);
    do_req("ld_w_10",    0, 2'd2, 0, 12'h010, 32'h0, 32'h8899AABB, 0, 0);
  endtask

  task automatic test_backpressure();
    do_req("st_w_20_hold", 1, 2'd2, 0, 12'h020, 32'h12345678, 32'h0, 0, 5);
    check_word("st_w_20", 8, 32'h12345678);
  endtask

  task automatic test_subword_store();
    do_req("st_b_11", 1, 2'd0, 0, 12'h011, 32'hFFFFFF5A, 32'h0, 0, 0);
    check_word("st_b_11", 4, 32'h88995ABB);
    do_req("st_h_22", 1, 2'd1, 0, 12'h022, 32'h0000BEEF, 32'h0, 0, 0);
    check_word("st_h_22", 8, 32'hBEEF5678);
    do_req("ld_w_20", 0, 2'd2, 0, 12'h020, 32'h0, 32'hBEEF5678, 0, 0);
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_CHK_EN
    do_req("ld_w_13",    0, 2'd2, 0, 12'h013, 32'h0, 32'h0, 1, 0);
    do_req("ld_rsv_10",  0, 2'd3, 0, 12'h010, 32'h0, 32'h0, 1, 0);
    do_req("ld_h_11",    0, 2'd1, 0, 12'h011, 32'h0, 32'h0, 1, 0);
    do_req("st_h_21",    1, 2'd1, 0, 12'h021, 32'h00001234, 32'h0, 1, 0);
    check_word("st_h_21", 8, 32'hBEEF5678);
`else
    do_req("ld_w_13",    0, 2'd2, 0, 12'h013, 32'h0, 32'h88995ABB, 0, 0);
    do_req("ld_rsv_10",  0, 2'd3, 0, 12'h010, 32'h0, 32'h88995ABB, 0, 0);
    do_req("ld_h_11",    0, 2'd1, 0, 12'h011, 32'h0, 32'h00005ABB, 0, 0);
    do_req("st_h_21",    1, 2'd1, 0, 12'h021, 32'h00001234, 32'h0, 0, 0);
    check_word("st_h_21", 8, 32'hBEEF1234);
`endif
  endtask

  task automatic test_reset_mrg();
    int wr0;
    do_req("ld_b_u_10", 0, 2'd0, 1, 12'h010, 32'h0, 32'h000000BB, 0, 0);
    wr0 = wr_cnt;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd0;
    req_unsigned = 1'b0;
    req_addr  = 12'h010;
    req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || mem_en !== 1'b0 || mem_wen !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mrg_during got rdy=%b en=%b wen=%b v=%b want 0 0 0 0",
                         req_ready, mem_en, mem_wen, rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mrg_after got v=%b rdy=%b d=%08h want 0 1 00000000",
                         rsp_valid, req_ready, rsp_rdata);
    end
    checks++;
    if (wr_cnt != wr0) begin
      errors++; $display("FAIL rst_mrg_writes got %0d want 0", wr_cnt - wr0);
    end
    check_word("rst_mrg", 4, 32'h88995ABB);
    @(posedge clk); #1;
    do_req("ld_w_post_rst", 0, 2'd2, 0, 12'h010, 32'h0, 32'h88995ABB, 0, 0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_backpressure();
    test_subword_store();
    test_misalign();
    test_reset_mrg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
